// File: rtl/mem_acc_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_acc_pkg;

    localparam int DW = 16;
    localparam int AW = 16;

    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_W  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC1 = 3'd1,
        CAP1 = 3'd2,
        ACC2 = 3'd3,
        CAP2 = 3'd4,
        RSP  = 3'd5
    } state_t;

endpackage

// File: rtl/mem_access_seq_if.sv
// Request/response and RAM-side signals of the sequencer. Handshake: a request
// transfers on the rising edge where req_valid && req_ready are both high.
interface mem_access_seq_if;
    import mem_acc_pkg::*;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic          req_wb;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_en;
    logic          mem_we;
    logic [1:0]    mem_be;
    logic [AW-2:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    state_t        dbg_state;

    modport master (
        output req_valid, req_we, req_wb, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, dbg_state
    );

    modport slave (
        input  req_valid, req_we, req_wb, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata, dbg_state
    );

endinterface

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: byte enables, write data placement and read-lane
// extraction for one access phase (phase 0 = first access, 1 = second).
module mem_lane_steer
    import mem_acc_pkg::*;
(
    input  logic          wb,
    input  logic          a0,
    input  logic          phase,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic [1:0]    be,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] rd_part
);

    always_comb begin
        be        = BE_W;
        mem_wdata = wdata;
        rd_part   = rdata;
        case ({wb, a0})
            2'b00: begin
                be        = BE_LO;
                mem_wdata = {wdata[7:0], wdata[7:0]};
                rd_part   = {8'h00, rdata[7:0]};
            end
            2'b01: begin
                be        = BE_HI;
                mem_wdata = {wdata[7:0], wdata[7:0]};
                rd_part   = {8'h00, rdata[15:8]};
            end
            2'b10: begin
                be        = BE_W;
                mem_wdata = wdata;
                rd_part   = rdata;
            end
            default: begin
                // Misaligned word: low byte lives in the odd lane of the
                // first word, high byte in the even lane of the next word.
                if (!phase) begin
                    be        = BE_HI;
                    mem_wdata = {wdata[7:0], 8'h00};
                    rd_part   = {8'h00, rdata[15:8]};
                end else begin
                    be        = BE_LO;
                    mem_wdata = {8'h00, wdata[15:8]};
                    rd_part   = {rdata[7:0], 8'h00};
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Memory access sequencer: CPU byte/word requests to a 16-bit RAM with byte
// enables. Define MEM_ACC_SPLIT_EN to split misaligned words; otherwise they are rejected.
module mem_access_seq
    import mem_acc_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mem_access_seq_if.slave bus
);

    state_t        state_q, state_d;
    logic          ready_q;
    logic          we_q, wb_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] rdata_q;
    logic          accept;
    logic          phase;
    logic          in_acc;
    logic [1:0]    be_s;
    logic [DW-1:0] wd_s, rd_part;

    assign accept = bus.req_valid && ready_q;

`ifdef MEM_ACC_SPLIT_EN
    logic split_q;
    assign split_q = wb_q && addr_q[0];
    assign phase   = (state_q == ACC2) || (state_q == CAP2);
`else
    logic err_q;
    assign phase = 1'b0;
`endif

    mem_lane_steer u_steer (
        .wb        (wb_q),
        .a0        (addr_q[0]),
        .phase     (phase),
        .wdata     (wdata_q),
        .rdata     (bus.mem_rdata),
        .be        (be_s),
        .mem_wdata (wd_s),
        .rd_part   (rd_part)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                acc_d = '0;
                if (accept) begin
`ifdef MEM_ACC_SPLIT_EN
                    state_d = ACC1;
`else
                    state_d = (bus.req_wb && bus.req_addr[0]) ? RSP : ACC1;
`endif
                end
            end
            ACC1: begin
`ifdef MEM_ACC_SPLIT_EN
                if (!we_q)        state_d = CAP1;
                else if (split_q) state_d = ACC2;
                else              state_d = RSP;
`else
                state_d = we_q ? RSP : CAP1;
`endif
            end
            CAP1: begin
                acc_d = acc_q | rd_part;
`ifdef MEM_ACC_SPLIT_EN
                state_d = split_q ? ACC2 : RSP;
`else
                state_d = RSP;
`endif
            end
`ifdef MEM_ACC_SPLIT_EN
            ACC2: state_d = we_q ? RSP : CAP2;
            CAP2: begin
                acc_d   = acc_q | rd_part;
                state_d = RSP;
            end
`endif
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            wb_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
`ifndef MEM_ACC_SPLIT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            acc_q   <= acc_d;
            if (accept) begin
                we_q    <= bus.req_we;
                wb_q    <= bus.req_wb;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
`ifndef MEM_ACC_SPLIT_EN
                err_q   <= bus.req_wb && bus.req_addr[0];
`endif
            end
            // Response data only changes on entry to RSP so it holds between responses.
            if ((state_d == RSP) && (state_q != RSP))
                rdata_q <= acc_d;
        end
    end

    assign in_acc = (state_q == ACC1) || (state_q == ACC2);

    always_comb begin
        bus.mem_addr = '0;
        if (state_q == ACC1)      bus.mem_addr = addr_q[AW-1:1];
        else if (state_q == ACC2) bus.mem_addr = addr_q[AW-1:1] + 15'd1;
    end

    assign bus.mem_en    = in_acc;
    assign bus.mem_we    = in_acc && we_q;
    assign bus.mem_be    = in_acc ? be_s : 2'b00;
    assign bus.mem_wdata = in_acc ? wd_s : '0;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == RSP);
    assign bus.rsp_rdata = rdata_q;
`ifdef MEM_ACC_SPLIT_EN
    assign bus.rsp_err   = 1'b0;
`else
    assign bus.rsp_err   = (state_q == RSP) && err_q;
`endif
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: table of requests against a RAM model,
// plus reset and reset-during-access sequences.
module tb_mem_access_seq;
    import mem_acc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_access_seq_if bus();

    mem_access_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM model: write with byte enables, read data valid the cycle after the strobe.
    logic [15:0] ram [0:32767];
    logic [15:0] ram_rd = 16'h0000;
    assign bus.mem_rdata = ram_rd;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                if (bus.mem_be[0]) ram[bus.mem_addr][7:0]  <= bus.mem_wdata[7:0];
                if (bus.mem_be[1]) ram[bus.mem_addr][15:8] <= bus.mem_wdata[15:8];
            end else begin
                ram_rd <= ram[bus.mem_addr];
            end
        end
    end

    typedef struct {
        logic        we;
        logic        wb;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nacc;
        logic [14:0] a1;
        logic [1:0]  be1;
        logic [15:0] wd1;
        logic [14:0] a2;
        logic [1:0]  be2;
        logic [15:0] wd2;
    } vec_t;

    vec_t vecs[$];

    logic [14:0] log_addr[$];
    logic [1:0]  log_be[$];
    logic [15:0] log_wd[$];
    logic        log_we[$];
    int          log_n[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic wb, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] exp_rd,
                                input logic exp_err, input int exp_lat, input int exp_nacc,
                                input logic [14:0] a1, input logic [1:0] be1, input logic [15:0] wd1,
                                input logic [14:0] a2, input logic [1:0] be2, input logic [15:0] wd2);
        vec_t v;
        v.we = we; v.wb = wb; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_nacc = exp_nacc;
        v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.a2 = a2; v.be2 = be2; v.wd2 = wd2;
        return v;
    endfunction

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_timeout", 32'(bus.req_ready), 32'd1);
    endtask

    // Issues one request, returns the response and logs every RAM strobe seen.
    task automatic do_req(input logic we, input logic wb, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rd,
                          output logic err, output int lat);
        rd  = 16'h0000;
        err = 1'b0;
        lat = -1;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_wb    = wb;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        log_addr.delete(); log_be.delete(); log_wd.delete(); log_we.delete(); log_n.delete();
        for (int n = 1; n <= 10 && lat < 0; n++) begin
            @(negedge clk);
            if (n == 1) bus.req_valid = 1'b0;
            if (n == 1) chk("ready_low_after_accept", 32'(bus.req_ready), 32'd0);
            if (bus.mem_en) begin
                log_addr.push_back(bus.mem_addr);
                log_be.push_back(bus.mem_be);
                log_wd.push_back(bus.mem_wdata);
                log_we.push_back(bus.mem_we);
                log_n.push_back(n);
            end
            if (bus.rsp_valid) begin
                lat = n;
                rd  = bus.rsp_rdata;
                err = bus.rsp_err;
            end
        end
        @(negedge clk);
        chk("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
        chk("rsp_rdata_held", 32'(bus.rsp_rdata), 32'(rd));
    endtask

    logic [15:0] got_rd;
    logic        got_err;
    int          got_lat;
    int          rsp_seen;

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 16'h0000;
        ram[15'h0010] = 16'h77C3;
        ram[15'h0018] = 16'h9988;
        ram[15'h0019] = 16'h6655;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wb    = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;

        vecs.push_back(mk(1, 1, 16'h0010, 16'hBEEF, 16'h0000, 0, 2, 1, 15'h0008, 2'b11, 16'hBEEF, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0010, 16'h0000, 16'hBEEF, 0, 3, 1, 15'h0008, 2'b11, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0021, 16'h005A, 16'h0000, 0, 2, 1, 15'h0010, 2'b10, 16'h5A5A, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0021, 16'h0000, 16'h005A, 0, 3, 1, 15'h0010, 2'b10, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0020, 16'h0000, 16'h5AC3, 0, 3, 1, 15'h0010, 2'b11, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0020, 16'h0000, 16'h00C3, 0, 3, 1, 15'h0010, 2'b01, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(1, 0, 16'h0020, 16'hFF11, 16'h0000, 0, 2, 1, 15'h0010, 2'b01, 16'h1111, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0020, 16'h0000, 16'h5A11, 0, 3, 1, 15'h0010, 2'b11, 16'h0000, 15'h0, 2'b00, 16'h0));
`ifdef MEM_ACC_SPLIT_EN
        vecs.push_back(mk(1, 1, 16'h0031, 16'h1234, 16'h0000, 0, 3, 2, 15'h0018, 2'b10, 16'h3400, 15'h0019, 2'b01, 16'h0012));
        vecs.push_back(mk(0, 1, 16'h0031, 16'h0000, 16'h1234, 0, 5, 2, 15'h0018, 2'b10, 16'h0000, 15'h0019, 2'b01, 16'h0000));
        vecs.push_back(mk(0, 0, 16'h0031, 16'h0000, 16'h0034, 0, 3, 1, 15'h0018, 2'b10, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0032, 16'h0000, 16'h0012, 0, 3, 1, 15'h0019, 2'b01, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0030, 16'h0000, 16'h3488, 0, 3, 1, 15'h0018, 2'b11, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 16'hA55A, 16'h0000, 0, 3, 2, 15'h7FFF, 2'b10, 16'h5A00, 15'h0000, 2'b01, 16'h00A5));
        vecs.push_back(mk(0, 1, 16'hFFFF, 16'h0000, 16'hA55A, 0, 5, 2, 15'h7FFF, 2'b10, 16'h0000, 15'h0000, 2'b01, 16'h0000));
        vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 16'h00A5, 0, 3, 1, 15'h0000, 2'b11, 16'h0000, 15'h0, 2'b00, 16'h0));
`else
        vecs.push_back(mk(1, 1, 16'h0031, 16'h1234, 16'h0000, 1, 1, 0, 15'h0, 2'b00, 16'h0, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0003, 16'h0000, 16'h0000, 1, 1, 0, 15'h0, 2'b00, 16'h0, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0031, 16'h0000, 16'h0099, 0, 3, 1, 15'h0018, 2'b10, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0032, 16'h0000, 16'h0055, 0, 3, 1, 15'h0019, 2'b01, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0030, 16'h0000, 16'h9988, 0, 3, 1, 15'h0018, 2'b11, 16'h0000, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(1, 1, 16'hFFFF, 16'hA55A, 16'h0000, 1, 1, 0, 15'h0, 2'b00, 16'h0, 15'h0, 2'b00, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 3, 1, 15'h0000, 2'b11, 16'h0000, 15'h0, 2'b00, 16'h0));
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_be",    32'(bus.mem_be),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_state",     32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].wb, vecs[i].addr, vecs[i].wdata, got_rd, got_err, got_lat);
            chk($sformatf("v%0d_latency", i), 32'(got_lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i),   32'(got_rd),  32'(vecs[i].exp_rd));
            chk($sformatf("v%0d_err", i),     32'(got_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_nacc", i),    32'(log_n.size()), 32'(vecs[i].exp_nacc));
            if (vecs[i].exp_nacc >= 1 && log_n.size() >= 1) begin
                chk($sformatf("v%0d_a1_cycle", i), 32'(log_n[0]),    32'd1);
                chk($sformatf("v%0d_a1_addr", i),  32'(log_addr[0]), 32'(vecs[i].a1));
                chk($sformatf("v%0d_a1_be", i),    32'(log_be[0]),   32'(vecs[i].be1));
                chk($sformatf("v%0d_a1_we", i),    32'(log_we[0]),   32'(vecs[i].we));
                if (vecs[i].we) chk($sformatf("v%0d_a1_wdata", i), 32'(log_wd[0]), 32'(vecs[i].wd1));
            end
            if (vecs[i].exp_nacc >= 2 && log_n.size() >= 2) begin
                chk($sformatf("v%0d_a2_cycle", i), 32'(log_n[1]),    vecs[i].we ? 32'd2 : 32'd3);
                chk($sformatf("v%0d_a2_addr", i),  32'(log_addr[1]), 32'(vecs[i].a2));
                chk($sformatf("v%0d_a2_be", i),    32'(log_be[1]),   32'(vecs[i].be2));
                if (vecs[i].we) chk($sformatf("v%0d_a2_wdata", i), 32'(log_wd[1]), 32'(vecs[i].wd2));
            end
        end

        // Reset asserted while the first read capture is in progress.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_wb    = 1'b1;
`ifdef MEM_ACC_SPLIT_EN
        bus.req_addr  = 16'h0031;
`else
        bus.req_addr  = 16'h0010;
`endif
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_in_acc1", 32'(bus.dbg_state), 32'(ACC1));
        @(negedge clk);
        chk("abort_in_cap1", 32'(bus.dbg_state), 32'(CAP1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_en",    32'(bus.mem_en),    32'd0);
        chk("abort_mem_be",    32'(bus.mem_be),    32'd0);
        chk("abort_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        chk("abort_state",     32'(bus.dbg_state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
        rsp_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_en) rsp_seen++;
        end
        chk("abort_no_response", 32'(rsp_seen), 32'd0);

        do_req(1'b0, 1'b1, 16'h0020, 16'h0000, got_rd, got_err, got_lat);
        chk("post_abort_rdata", 32'(got_rd),  32'h5A11);
        chk("post_abort_lat",   32'(got_lat), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
